// File: rtl/d_mul_rot_uni.sv
// Deterministic unipolar stochastic multiplier (rotation method).
// The B unary stream lags one extra cycle per A period, so every A/B phase pair occurs once per window.
module d_mul_rot_uni #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             loadA,
    input  logic             loadB,
    output logic             oC
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] cnta_q, cnta_d;
    logic [WIDTH-1:0] cntb_q, cntb_d;
    logic             oc_q, oc_d;
    logic             bit_a, bit_b;

    assign bit_a = (cnta_q < ra_q);
    assign bit_b = (cntb_q < rb_q);

    always_comb begin
        ra_d   = ra_q;
        rb_d   = rb_q;
        cnta_d = cnta_q + CNT_ONE;
        cntb_d = cntb_q + CNT_ONE;
        oc_d   = bit_a & bit_b;

        if (loadA) ra_d = iA;
        if (loadB) rb_d = iB;

        // Any load starts a fresh product window with the rotation phase cleared.
        if (loadA || loadB) begin
            cnta_d = '0;
            cntb_d = '0;
        end else if (cnta_q == CNT_MAX) begin
            cntb_d = cntb_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_q   <= '0;
            rb_q   <= '0;
            cnta_q <= '0;
            cntb_q <= '0;
            oc_q   <= 1'b0;
        end else begin
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            cnta_q <= cnta_d;
            cntb_q <= cntb_d;
            oc_q   <= oc_d;
        end
    end

    assign oC = oc_q;

endmodule

// File: tb/tb_d_mul_rot_uni.sv
// Bench for d_mul_rot_uni at a reduced width so full product windows stay short.
module tb_d_mul_rot_uni;

    localparam int W    = 6;
    localparam int P    = 1 << W;
    localparam int WIN  = P * P;
    localparam int HALF = P / 2;
    localparam int MAXV = P - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] iA, iB;
    logic         loadA, loadB;
    logic         oC;

    int n_cmp = 0;
    int n_bad = 0;

    d_mul_rot_uni #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .iA    (iA),
        .iB    (iB),
        .loadA (loadA),
        .loadB (loadB),
        .oC    (oC)
    );

    always #5 clk = ~clk;

    // Reference: t cycles after a load, A phase is t mod P and the B phase lags
    // by one per completed A period.
    function automatic bit model_bit(input int a, input int b, input int t);
        int ca, k, cb;
        ca = t % P;
        k  = (t / P) % P;
        cb = (ca - k + P) % P;
        return (ca < a) && (cb < b);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input int a, input int b, input bit la, input bit lb);
        iA    = W'(a);
        iB    = W'(b);
        loadA = la;
        loadB = lb;
        @(posedge clk);
        #1;
        loadA = 1'b0;
        loadB = 1'b0;
    endtask

    task automatic run_window(input int a, input int b, input int n,
                              output int ones, output int bad);
        ones = 0;
        bad  = 0;
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            if (oC === 1'b1) ones++;
            if (oC !== model_bit(a, b, t)) bad++;
        end
    endtask

    int ones, bad, ra, rb;

    initial begin
        rst   = 1'b1;
        iA    = W'(HALF);
        iB    = W'(HALF);
        loadA = 1'b0;
        loadB = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_oC", int'(oC), 0);
        check("reset_rA", int'(dut.ra_q), 0);
        rst = 1'b0;
        run_window(0, 0, 1000, ones, bad);
        check("idle_ones", ones, 0);

        do_load(HALF, HALF, 1'b1, 1'b1);
        run_window(HALF, HALF, WIN, ones, bad);
        check("half_half_ones", ones, HALF * HALF);
        check("half_half_bits", bad, 0);

        do_load(0, MAXV, 1'b1, 1'b1);
        run_window(0, MAXV, WIN, ones, bad);
        check("zero_max_ones", ones, 0);

        do_load(MAXV, MAXV, 1'b1, 1'b1);
        run_window(MAXV, MAXV, WIN, ones, bad);
        check("max_max_ones", ones, MAXV * MAXV);
        check("max_max_bits", bad, 0);

        do_load(HALF, HALF / 2, 1'b1, 1'b1);
        run_window(HALF, HALF / 2, WIN, ones, bad);
        check("asym_ones", ones, HALF * HALF / 2);
        check("asym_bits", bad, 0);

        do_load(HALF / 2, HALF, 1'b1, 1'b1);
        run_window(HALF / 2, HALF, WIN, ones, bad);
        check("swap_ones", ones, HALF * HALF / 2);

        // Partial load: only B changes, A keeps its value, counters restart.
        do_load(HALF, HALF, 1'b1, 1'b1);
        run_window(HALF, HALF, 300, ones, bad);
        check("pre_partial_bits", bad, 0);
        do_load(5, P / 8, 1'b0, 1'b1);
        check("partial_rA", int'(dut.ra_q), HALF);
        run_window(HALF, P / 8, WIN, ones, bad);
        check("partial_ones", ones, HALF * (P / 8));
        check("partial_bits", bad, 0);

        // Asynchronous reset between edges while oC is high.
        do_load(HALF, HALF, 1'b1, 1'b1);
        run_window(HALF, HALF, 150, ones, bad);
        check("pre_reset_oC", int'(oC), 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_oC", int'(oC), 0);
        check("async_rA", int'(dut.ra_q), 0);
        check("async_rB", int'(dut.rb_q), 0);
        #1;
        rst = 1'b0;
        run_window(0, 0, 20, ones, bad);
        check("post_reset_ones", ones, 0);
        do_load(HALF, HALF, 1'b1, 1'b1);
        run_window(HALF, HALF, WIN, ones, bad);
        check("reload_ones", ones, HALF * HALF);

        for (int i = 0; i < 3; i++) begin
            ra = int'($urandom_range(0, MAXV));
            rb = int'($urandom_range(0, MAXV));
            do_load(ra, rb, 1'b1, 1'b1);
            run_window(ra, rb, WIN, ones, bad);
            check("rand_ones", ones, ra * rb);
            check("rand_bits", bad, 0);
        end

        // Random loadA-only restart keeps the previous B.
        ra = int'($urandom_range(0, MAXV));
        do_load(ra, int'($urandom_range(0, MAXV)), 1'b1, 1'b0);
        run_window(ra, rb, WIN, ones, bad);
        check("rand_loadA_ones", ones, ra * rb);
        check("rand_loadA_bits", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
